seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 16: match-counter width in bits.
REQ-003 Parameter LEN_W, default $clog2(PAT_W+1): width of the pattern-length port; derived, not overridden.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in_vld  input  1  in_bit is valid this cycle.
REQ-007 in_bit  input  1  serial data bit.
REQ-008 cfg_load  input  1  single-cycle strobe that latches pat, pat_len and overlap.
REQ-009 pat  input  PAT_W  pattern; pat[pat_len-1] is the first bit expected, pat[0] the last.
REQ-010 pat_len  input  LEN_W  pattern length in bits.
REQ-011 overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
REQ-012 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-013 match  output  1  registered Moore flag, high for one cycle per detection.
REQ-014 cfg_err  output  1  last cfg_load held an illegal length.
REQ-015 armed  output  1  a legal configuration is held (FSM in S_RUN).
REQ-016 match_cnt  output  CNT_W  saturating detection count.

Function
REQ-017 The FSM SHALL have two states: S_IDLE (unconfigured) and S_RUN.
- cfg_load with 2 <= pat_len <= PAT_W: go to S_RUN and set cfg_err=0.
- cfg_load with any other pat_len: go to S_IDLE and set cfg_err=1.
REQ-018 Every cfg_load SHALL clear the history register hist[PAT_W-1:0] and the fill counter fill.
REQ-019 In S_RUN, each in_vld=1 cycle SHALL shift hist left with in_bit entering bit 0, and increment fill, saturating at PAT_W.
REQ-020 Detection SHALL occur on an accepted bit when the updated fill >= len and the updated hist[len-1:0] == pat_q[len-1:0], where pat_q and len are the latched values.
REQ-021 match SHALL be high in the cycle after the clock edge that accepts the completing bit, for exactly one cycle; latency is 1 clk from in_vld.
REQ-022 Overlap behaviour on detection:
- overlap_q=1: fill is retained.
- overlap_q=0: fill is set to 0, so the next detection needs len fresh bits.
REQ-023 in_vld=0 cycles SHALL leave hist, fill and match_cnt unchanged, and drive match=0.
REQ-024 cfg_load and in_vld in the same cycle: cfg_load wins, in_bit is discarded, match=0 next cycle.
REQ-025 In S_IDLE, in_bit SHALL be ignored and match SHALL stay 0.
REQ-026 match_cnt SHALL increment by 1 per detection and hold at 2^CNT_W-1 (no wrap).
REQ-027 cnt_clr SHALL take priority over a coincident detection: the count becomes 0, but match still asserts.
REQ-028 cfg_load SHALL NOT clear match_cnt.

Reset
REQ-029 On rst, the block SHALL enter S_IDLE, clear hist, fill, pat_q, len and overlap_q, and drive match=0, cfg_err=0, armed=0, match_cnt=0.
REQ-030 rst asserted mid-pattern SHALL discard the partial match; after release, no match is possible until a new cfg_load.

Configuration
REQ-031 Macro SEQ_DETECT_CNT_EN SHALL control the match counter.
- Defined: match_cnt and cnt_clr behave per REQ-026..028.
- Undefined: no counter registers exist, match_cnt is tied to 0, and cnt_clr is ignored; all other behaviour is identical.

Structure
REQ-032 Package seq_detect_pkg SHALL hold the state enum (S_IDLE, S_RUN) and the PAT_W legal-range constants.
REQ-033 The saturating counter SHALL be sub-module seq_det_sat_cnt (CNT_W, inc, clr), instantiated only under SEQ_DETECT_CNT_EN.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Load pat=4'b1011, len=4, overlap=1; feed 1,0,1,1,0,1,1 -> match high after bit 4 and after bit 7; match_cnt=2.
- Same pattern with overlap=0; feed 1,0,1,1,0,1,1 -> match after bit 4 only; match_cnt=1.
- Load len=0, then len=PAT_W+1 -> cfg_err=1 and armed=0 each time; a stream containing the old pattern gives no match.
- Assert rst after bits 1,0,1 of 1011; release and reload; feed 1 -> no match; a full 1,0,1,1 -> match.
- With CNT_W=2, produce 5 detections -> match_cnt holds 3; cnt_clr coincident with the 6th detection -> match=1, match_cnt=0.
- Insert in_vld=0 gaps inside 1,0,1,1 -> match once, 1 cycle after the last valid bit; cfg_load coincident with in_vld -> the bit is dropped.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parameterised serial sequence detector.
// Holds the two-state FSM encoding and the legal pattern-length bounds.
package seq_detect_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // PAT_W_MIN also serves as the shortest legal runtime pattern length.
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter for detection events; clr wins over inc and the
// count sticks at all-ones instead of wrapping.
module seq_det_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector (overlapping or not).
// Define SEQ_DETECT_CNT_EN to build the saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic             cfg_err,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] hist, hist_nxt, pat_q, len_mask;
  logic [LEN_W-1:0] fill, fill_nxt, len;
  logic             overlap_q;
  logic             len_ok, accept, det;

  assign len_ok = (pat_len >= LEN_W'(PAT_W_MIN)) && (pat_len <= LEN_W'(PAT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cfg_load) state_nxt = len_ok ? S_RUN : S_IDLE;
  end

  // cfg_load takes precedence, so a coincident data bit is never shifted in.
  always_comb begin
    armed    = (state == S_RUN);
    accept   = armed && in_vld && !cfg_load;
    hist_nxt = {hist[PAT_W-2:0], in_bit};
    fill_nxt = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) len_mask[i] = (32'(i) < 32'(len));
    det      = accept && (fill_nxt >= len) && (((hist_nxt ^ pat_q) & len_mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat_q     <= '0;
      len       <= '0;
      overlap_q <= 1'b0;
      cfg_err   <= 1'b0;
      match     <= 1'b0;
    end else begin
      match <= det;
      if (cfg_load) begin
        pat_q     <= pat;
        len       <= pat_len;
        overlap_q <= overlap;
        cfg_err   <= !len_ok;
        hist      <= '0;
        fill      <= '0;
      end else if (accept) begin
        hist <= hist_nxt;
        fill <= (det && !overlap_q) ? '0 : fill_nxt;
      end
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (det),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and randomized bench for seq_detect_param against a queue-based
// model of the accepted bit stream.
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_vld = 1'b0, in_bit = 1'b0, cfg_load = 1'b0;
  logic [PAT_W-1:0] pat = '0;
  logic [LEN_W-1:0] pat_len = '0;
  logic             overlap = 1'b0, cnt_clr = 1'b0;
  logic             match, cfg_err, armed;
  logic [CNT_W-1:0] match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the bits accepted since the last reload or
  // non-overlapping detection, plus the latched configuration.
  bit   q[$];
  bit   [PAT_W-1:0] m_pat;
  int   m_len;
  bit   m_ovl, m_armed, m_err, exp_match;
  int   exp_cnt;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_bit    (in_bit),
    .cfg_load  (cfg_load),
    .pat       (pat),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .match     (match),
    .cfg_err   (cfg_err),
    .armed     (armed),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".match"}, int'(match), int'(exp_match));
    check({tag, ".armed"}, int'(armed), int'(m_armed));
    check({tag, ".cfg_err"}, int'(cfg_err), int'(m_err));
    check({tag, ".cnt"}, int'(match_cnt), exp_cnt);
  endtask

  function automatic bit model_hit();
    if (q.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pat = '0; m_len = 0; m_ovl = 0; m_armed = 0; m_err = 0;
    exp_match = 0; exp_cnt = 0;
  endfunction

  // One clock: apply inputs, advance model at the edge, compare just after it.
  task automatic step(input logic v, input logic b, input logic c, input logic clr,
                      input string tag);
    bit hit;
    in_vld = v; in_bit = b; cfg_load = c; cnt_clr = clr;
    @(posedge clk);
    hit = 1'b0;
    if (c) begin
      m_pat   = pat;
      m_len   = int'(pat_len);
      m_ovl   = overlap;
      m_armed = (m_len >= 2) && (m_len <= PAT_W);
      m_err   = !m_armed;
      q.delete();
    end else if (m_armed && v) begin
      q.push_back(b);
      if (q.size() > PAT_W) void'(q.pop_front());
      hit = model_hit();
      if (hit && !m_ovl) q.delete();
    end
    exp_match = hit;
`ifdef SEQ_DETECT_CNT_EN
    if (clr) exp_cnt = 0;
    else if (hit && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
    #1;
    in_vld = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    check_all(tag);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input int l, input logic o, input string tag);
    pat = p; pat_len = LEN_W'(l); overlap = o;
    step(1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    do_reset("reset");

    // Overlapping 1011: hits after bits 4 and 7.
    load(8'b1011, 4, 1'b1, "ovl_load");
    feed(32'b1011011, 7, "ovl_feed");
    step(1'b0, 1'b0, 1'b0, 1'b1, "clr");

    // Non-overlapping 1011: only the first hit.
    load(8'b1011, 4, 1'b0, "novl_load");
    feed(32'b1011011, 7, "novl_feed");

    // Illegal lengths disarm and flag an error.
    load(8'b1011, 0, 1'b1, "len0");
    feed(32'b1011, 4, "len0_feed");
    load(8'b1011, PAT_W + 1, 1'b1, "len9");
    feed(32'b1011011, 7, "len9_feed");

    // Reset mid-pattern drops the partial match and disarms.
    load(8'b1011, 4, 1'b1, "rst_load");
    feed(32'b101, 3, "rst_part");
    do_reset("rst_mid");
    feed(32'b1011, 4, "rst_unarmed");
    load(8'b1011, 4, 1'b1, "rst_reload");
    feed(32'b1, 1, "rst_one");
    feed(32'b1011, 4, "rst_full");

    // Saturation with CNT_W=2, then clear coincident with a detection.
    step(1'b0, 1'b0, 1'b0, 1'b1, "sat_clr0");
    load(8'b11, 2, 1'b1, "sat_load");
    feed(32'b111111, 6, "sat_feed");
    step(1'b1, 1'b1, 1'b0, 1'b1, "sat_clr_hit");

    // Gaps inside the pattern.
    load(8'b1011, 4, 1'b1, "gap_load");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap");
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap");
    step(1'b1, 1'b0, 1'b0, 1'b0, "gap");
    step(1'b0, 1'b1, 1'b0, 1'b0, "gap");
    step(1'b0, 1'b1, 1'b0, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, 1'b0, "gap_last");
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap_after");

    // cfg_load with in_vld: the coincident bit is dropped.
    pat = 8'b1011; pat_len = 4; overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, "coinc_load");
    feed(32'b011, 3, "coinc_tail");
    feed(32'b1011, 4, "coinc_full");

    // Full-width pattern.
    load(8'b10010110, PAT_W, 1'b0, "w8_load");
    feed(32'b1001011010010110, 16, "w8_feed");

    // Randomized traffic with periodic reconfiguration.
    for (int r = 0; r < 12; r++) begin
      load(PAT_W'($urandom), $urandom_range(0, PAT_W + 1), 1'($urandom_range(0, 1)), "rnd_load");
      for (int i = 0; i < 60; i++)
        step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
             1'($urandom_range(0, 15) == 0), "rnd");
    end
    for (int r = 0; r < 8; r++) begin
      logic [PAT_W-1:0] p;
      int               l;
      l = $urandom_range(2, 4);
      p = PAT_W'($urandom_range(0, (1 << l) - 1));
      load(p, l, 1'($urandom_range(0, 1)), "rnd_short_load");
      for (int i = 0; i < 80; i++)
        step(1'($urandom_range(0, 4) != 0), 1'($urandom), 1'b0,
             1'($urandom_range(0, 20) == 0), "rnd_short");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
